// File: rtl/branch_predict_resolve_if.sv
// branch_predict_resolve_if: IF lookup and ID resolve signals of the branch unit
interface branch_predict_resolve_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int CNT_W  = 16
);
  logic [PC_W-1:0]   if_pc;
  logic              if_pred_taken;
  logic [PC_W-1:0]   if_pred_target;
  logic              id_valid;
  logic              id_stall;
  logic              id_branch;
  logic              id_jump;
  logic [1:0]        id_cond;
  logic [DATA_W-1:0] id_data;
  logic [PC_W-1:0]   id_pc;
  logic [PC_W-1:0]   id_target;
  logic              id_pred_taken;
  logic [PC_W-1:0]   id_pred_target;
  logic [2:0]        pc_src;
  logic              if_flush;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;
  modport master (
    output if_pc, id_valid, id_stall, id_branch, id_jump, id_cond, id_data,
           id_pc, id_target, id_pred_taken, id_pred_target,
    input  if_pred_taken, if_pred_target, pc_src, if_flush, branch_cnt, mispred_cnt
  );
  modport slave (
    input  if_pc, id_valid, id_stall, id_branch, id_jump, id_cond, id_data,
           id_pc, id_target, id_pred_taken, id_pred_target,
    output if_pred_taken, if_pred_target, pc_src, if_flush, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: BTB-based branch predictor with ID-stage resolution and redirect
module branch_predict_resolve #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst_n,
  branch_predict_resolve_if.slave bus
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 1;
  logic [N-1:0]      vld;
  logic [TAG_W-1:0]  tag [N];
  logic [PC_W-1:0]   tgt [N];
  logic [1:0]        ctr [N];
  logic [IDX_W-1:0]  if_idx, id_idx;
  logic [TAG_W-1:0]  if_tag, id_tag;
  logic              if_hit, id_hit, taken, jump_ev, resolve, mis_t, mis_n, mispred;
  logic              unused_pc_lsb;
  assign unused_pc_lsb = bus.if_pc[0] ^ bus.id_pc[0];
  assign if_idx = bus.if_pc[IDX_W:1];
  assign if_tag = bus.if_pc[PC_W-1:IDX_W+1];
  assign id_idx = bus.id_pc[IDX_W:1];
  assign id_tag = bus.id_pc[PC_W-1:IDX_W+1];
  // IF lookup: combinational, sees the entry as it stood before this cycle's update
  always_comb begin
    if_hit = vld[if_idx] && (tag[if_idx] == if_tag);
    bus.if_pred_taken = rst_n && if_hit && ctr[if_idx][1];
    bus.if_pred_target = bus.if_pred_taken ? tgt[if_idx] : '0;
  end
  // ID resolution: condition evaluation, misprediction detection, next-PC select
  always_comb begin
    id_hit = vld[id_idx] && (tag[id_idx] == id_tag);
    taken = bus.id_cond[1] ? (bus.id_data[DATA_W-1] ^ bus.id_cond[0])
                           : ((bus.id_data == '0) ^ bus.id_cond[0]);
    jump_ev = bus.id_valid && !bus.id_stall && bus.id_jump;
    resolve = bus.id_valid && !bus.id_stall && bus.id_branch && !bus.id_jump;
    mis_t = taken && (!bus.id_pred_taken || (bus.id_pred_target != bus.id_target));
    mis_n = !taken && bus.id_pred_taken;
    mispred = resolve && (mis_t || mis_n);
    bus.pc_src = !rst_n ? 3'b001 :
                 jump_ev ? (bus.id_cond[0] ? 3'b010 : 3'b100) :
                 !resolve ? 3'b001 :
                 mis_t ? 3'b011 :
                 mis_n ? 3'b101 : 3'b001;
    bus.if_flush = rst_n && (jump_ev || mispred);
  end
  // BTB training: strengthen/retarget on hit, allocate weakly-taken on taken miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < N; i++) begin
        tag[i] <= '0;
        tgt[i] <= '0;
        ctr[i] <= 2'b00;
      end
    end else if (resolve) begin
      if (id_hit) begin
        ctr[id_idx] <= taken ? (ctr[id_idx] == 2'b11 ? 2'b11 : ctr[id_idx] + 2'd1)
                             : (ctr[id_idx] == 2'b00 ? 2'b00 : ctr[id_idx] - 2'd1);
        if (taken) tgt[id_idx] <= bus.id_target;
      end else if (taken) begin
        vld[id_idx] <= 1'b1;
        tag[id_idx] <= id_tag;
        tgt[id_idx] <= bus.id_target;
        ctr[id_idx] <= 2'b10;
      end
    end
  end
  // Statistics: saturating branch and mispredict counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.branch_cnt <= '0;
      bus.mispred_cnt <= '0;
    end else begin
      if (resolve && !(&bus.branch_cnt)) bus.branch_cnt <= bus.branch_cnt + 1'b1;
      if (mispred && !(&bus.mispred_cnt)) bus.mispred_cnt <= bus.mispred_cnt + 1'b1;
    end
  end
endmodule

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Parametrised branch resolution unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It sits across IF and ID. In IF it supplies a taken prediction and target for the fetch PC. In ID it evaluates the BEQZ/BNEZ/BLTZ/BGEZ condition on the forwarded register value, detects mispredictions, selects the next-PC source and flushes IF. It also updates the BTB and keeps branch and mispredict statistics.

## Interface
- DATA_W, 16: width of tested register value.
- PC_W, 16: PC width. PCs are halfword-aligned, so bit 0 is ignored.
- IDX_W, 3: BTB index bits. The BTB has 2^IDX_W entries.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  PC_W  fetch PC.
- if_pred_taken  out  1  BTB hit and counter MSB set.
- if_pred_target  out  PC_W  predicted target; 0 when if_pred_taken=0.
- id_valid  in  1  ID holds a real instruction.
- id_stall  in  1  ID is stalled by a hazard; its contents are not final.
- id_branch  in  1  ID instruction is a conditional branch.
- id_jump  in  1  ID instruction is a jump.
- id_cond  in  2  instr[12:11]: 00 BEQZ, 01 BNEZ, 10 BLTZ, 11 BGEZ. For jumps, bit 0=1 means register jump.
- id_data  in  DATA_W  forwarded Rs value.
- id_pc  in  PC_W  PC of the ID instruction.
- id_target  in  PC_W  computed branch target.
- id_pred_taken  in  1  prediction carried down the pipeline from IF.
- id_pred_target  in  PC_W  predicted target carried down the pipeline from IF.
- pc_src  out  3  next-PC select (encoding below).
- if_flush  out  1  squash the instruction in IF.
- branch_cnt  out  CNT_W  number of resolved branches.
- mispred_cnt  out  CNT_W  number of resolved mispredictions.

## Operation
- BTB entry: valid, tag = pc[PC_W-1:IDX_W+1], target, 2-bit counter. Index = pc[IDX_W:1].
- IF lookup is combinational. A hit requires valid and tag match.
- Actual outcome ("taken") by condition:
  - BEQZ: data==0.
  - BNEZ: data!=0.
  - BLTZ: data[DATA_W-1]=1.
  - BGEZ: data[DATA_W-1]=0.
- A resolve event is id_valid & ~id_stall & id_branch. id_jump has priority if both id_branch and id_jump are set.
- pc_src encoding:
  - 001: sequential.
  - 011: branch target.
  - 100: jump immediate.
  - 010: jump register.
  - 101: recover to id_pc+2.
- pc_src and if_flush by case:
  - No event, or id_stall=1, or rst_n low: pc_src=001, if_flush=0.
  - Jump: pc_src=100 if id_cond[0]=0, else 010; if_flush=1. A jump does not touch the BTB or the counters.
  - Taken, and (id_pred_taken=0 or id_pred_target!=id_target): pc_src=011, if_flush=1. Counts as a mispredict.
  - Not taken and id_pred_taken=1: pc_src=101, if_flush=1. Counts as a mispredict.
  - Otherwise the prediction was correct: pc_src=001, if_flush=0.
- BTB update on a resolve event, at the clock edge:
  - Hit, taken: counter incremented, saturating at 11; target overwritten with id_target.
  - Hit, not taken: counter decremented, saturating at 00.
  - Miss, taken: entry allocated with valid=1, tag, target=id_target, counter=10.
  - Miss, not taken: no write.
- Statistics:
  - branch_cnt increments on every resolve event.
  - mispred_cnt increments on every mispredict.
  - Both saturate at all-ones and never wrap.

## Timing
- pc_src, if_flush, if_pred_taken and if_pred_target are combinational, giving a zero-cycle redirect from ID.
- BTB writes and counter changes become visible one cycle after the resolve edge.
- If IF and ID use the same index in the same cycle, IF sees the pre-update entry. There is no bypass.
- Asynchronous reset, effective immediately, forces:
  - all BTB valid bits to 0;
  - both counters to 0;
  - if_pred_taken=0, if_pred_target=0;
  - pc_src=001, if_flush=0.
- Reset asserted mid-operation discards any pending update. After rst_n rises, the first edge is a normal edge.
- A stall held for multiple cycles produces no updates and no redirects. The branch resolves exactly once, in the first cycle with id_stall=0.

## Test plan
- Reset, then if_pc=0x0010 -> if_pred_taken=0, if_pred_target=0x0000, pc_src=001, counters=0.
- BEQZ at id_pc=0x0010, data=0, id_target=0x0040, id_pred_taken=0 -> pc_src=011, if_flush=1, mispred_cnt=1. Next cycle with if_pc=0x0010 -> if_pred_taken=1, if_pred_target=0x0040.
- Same branch resolved not-taken (data=5) with id_pred_taken=1, id_pred_target=0x0040 -> pc_src=101, if_flush=1; counter goes 10→01; next lookup of 0x0010 gives if_pred_taken=0.
- BLTZ with data=0x8000 and BGEZ with data=0x7FFF, both correctly predicted taken with matching target -> pc_src=001, if_flush=0, branch_cnt+2, mispred_cnt unchanged.
- Jump with id_cond=10 -> pc_src=100, if_flush=1. Jump with id_cond=11 -> pc_src=010, if_flush=1. No BTB or counter change in either case.
- id_stall=1 for 3 cycles on a taken mispredicted branch -> pc_src=001 for all 3 cycles. On the release cycle -> 011 once, branch_cnt+1. With CNT_W=2, 4 resolves -> branch_cnt=3 (saturated).
